// File: rtl/sp_ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package sp_ram_arb_pkg;

    typedef enum logic [1:0] {
        OwnerNone,
        OwnerInstr,
        OwnerData,
        OwnerDataErr
    } owner_e;

    function automatic int unsigned stall_w(input int unsigned max_stall);
        return $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/sp_ram_arb_age_ctr.sv
// Saturating count of consecutive cycles the fetch port has lost arbitration.
module sp_ram_arb_age_ctr
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int unsigned CntW = stall_w(MAX_STALL);

    logic [CntW-1:0] r_cnt;
    logic            w_at_max;

    assign w_at_max = (r_cnt == CntW'(MAX_STALL));
    assign o_at_max = w_at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one sp_ram between fetch (read-only) and LSU (read/write) ports; data has priority,
// with an age counter to avoid fetch starvation. SP_RAM_ARB_PERF_EN adds conflict_cnt_o.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 256,
    parameter int unsigned MAX_STALL  = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,

    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
`ifdef SP_RAM_ARB_PERF_EN
    ,
    output logic [31:0]             conflict_cnt_o
`endif
);

    owner_e r_owner;
    logic   r_data_we;
    logic   w_at_max;
    logic   w_instr_gnt;
    logic   w_data_gnt;
    logic   w_in_range;

    assign w_in_range = (32'(data_addr_i) < 32'(NUM_WORDS));

    // Fetch wins only once it has lost MAX_STALL cycles in a row.
    assign w_instr_gnt = !rst && instr_req_i && (!data_req_i || w_at_max);
    assign w_data_gnt  = !rst && data_req_i && !(instr_req_i && w_at_max);

    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    sp_ram_arb_age_ctr #(
        .MAX_STALL (MAX_STALL)
    ) u_age_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (instr_req_i && !w_instr_gnt),
        .i_clr    (w_instr_gnt || !instr_req_i),
        .o_at_max (w_at_max)
    );

    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        // An out-of-range data access is granted but never reaches the macro.
        if (w_data_gnt && w_in_range) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = data_addr_i;
            ram_we_o    = data_we_i;
            ram_be_o    = data_be_i;
            ram_wdata_o = data_wdata_i;
        end else if (w_instr_gnt) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = instr_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= OwnerNone;
            r_data_we <= 1'b0;
        end else begin
            r_data_we <= w_data_gnt && data_we_i;
            if (w_data_gnt) begin
                r_owner <= w_in_range ? OwnerData : OwnerDataErr;
            end else if (w_instr_gnt) begin
                r_owner <= OwnerInstr;
            end else begin
                r_owner <= OwnerNone;
            end
        end
    end

    assign instr_rvalid_o = (r_owner == OwnerInstr);
    assign data_rvalid_o  = (r_owner == OwnerData) || (r_owner == OwnerDataErr);
    assign data_err_o     = (r_owner == OwnerDataErr);
    assign instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : '0;
    assign data_rdata_o   = ((r_owner == OwnerData) && !r_data_we) ? ram_rdata_i : '0;

`ifdef SP_RAM_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (instr_req_i && data_req_i && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_sp_ram_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_gnt;
    logic          instr_rvalid;
    logic [DW-1:0] instr_rdata;
    logic          data_req;
    logic [AW-1:0] data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [DW-1:0] data_wdata;
    logic          data_gnt;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          data_err;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
`ifdef SP_RAM_ARB_PERF_EN
    logic [31:0]   conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:63];

    sp_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (256),
        .MAX_STALL  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .ram_en_o       (ram_en),
        .ram_addr_o     (ram_addr),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
`ifdef SP_RAM_ARB_PERF_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
            ram_rdata <= mem[ram_addr[7:2]];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req  = 1'b0;
        instr_addr = '0;
        data_req   = 1'b0;
        data_addr  = '0;
        data_we    = 1'b0;
        data_be    = '0;
        data_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        ram_rdata = 32'h1234_5678;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if ({instr_gnt, data_gnt, ram_en} !== 3'b000) begin
            $display("FAIL reset_gnt: got %b want 000", {instr_gnt, data_gnt, ram_en});
            errors++;
        end
        checks++;
        if ({instr_rvalid, data_rvalid, data_err} !== 3'b000) begin
            $display("FAIL reset_rvalid: got %b want 000", {instr_rvalid, data_rvalid, data_err});
            errors++;
        end
        checks++;
        if ((instr_rdata !== 32'h0) || (data_rdata !== 32'h0)) begin
            $display("FAIL reset_rdata: got %h/%h want 0/0", instr_rdata, data_rdata);
            errors++;
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_write_then_fetch();
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h010;
        data_be = 4'hF; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({data_gnt, instr_gnt, ram_en, ram_we, ram_be} !== 8'b1011_1111 || ram_addr !== 9'h010) begin
            $display("FAIL wr_grant: got g=%b i=%b en=%b we=%b be=%h a=%h want 1 0 1 1 f 010",
                     data_gnt, instr_gnt, ram_en, ram_we, ram_be, ram_addr);
            errors++;
        end
        next_cycle();
        idle_inputs();
        instr_req = 1'b1; instr_addr = 9'h010;
        @(negedge clk);
        checks++;
        if ({data_rvalid, data_err} !== 2'b10 || data_rdata !== 32'h0) begin
            $display("FAIL wr_resp: got rv=%b err=%b rd=%h want 1 0 0", data_rvalid, data_err,
                     data_rdata);
            errors++;
        end
        checks++;
        if ({instr_gnt, ram_en, ram_we, ram_be} !== 7'b110_0000 || ram_addr !== 9'h010) begin
            $display("FAIL if_grant: got g=%b en=%b we=%b be=%h a=%h want 1 1 0 0 010",
                     instr_gnt, ram_en, ram_we, ram_be, ram_addr);
            errors++;
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (instr_rvalid !== 1'b1 || instr_rdata !== 32'hDEAD_BEEF || ram_en !== 1'b0) begin
            $display("FAIL if_resp: got rv=%b rd=%h en=%b want 1 deadbeef 0", instr_rvalid,
                     instr_rdata, ram_en);
            errors++;
        end
        next_cycle();
    endtask

    task automatic test_byte_enable();
        data_req = 1'b1; data_we = 1'b1; data_addr = 9'h010;
        data_be = 4'b0010; data_wdata = 32'h0000_AB00;
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1 || ram_be !== 4'b0010) begin
            $display("FAIL be_wr: got g=%b be=%b want 1 0010", data_gnt, ram_be);
            errors++;
        end
        next_cycle();
        data_we = 1'b0; data_be = 4'h0; data_wdata = '0;
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1 || ram_we !== 1'b0) begin
            $display("FAIL be_rd_grant: got g=%b we=%b want 1 0", data_gnt, ram_we);
            errors++;
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (data_rvalid !== 1'b1 || data_err !== 1'b0 || data_rdata !== 32'hDEAD_ABEF) begin
            $display("FAIL be_rd_data: got rv=%b err=%b rd=%h want 1 0 deadabef", data_rvalid,
                     data_err, data_rdata);
            errors++;
        end
        next_cycle();
    endtask

    task automatic test_age();
        logic want_i;
        data_req = 1'b1; data_addr = 9'h010;
        instr_req = 1'b1; instr_addr = 9'h010;
        for (int k = 0; k < 10; k++) begin
            want_i = (k == 4) || (k == 9);
            @(negedge clk);
            checks++;
            if (instr_gnt !== want_i || data_gnt !== !want_i) begin
                $display("FAIL age_cycle%0d: got i=%b d=%b want i=%b d=%b", k + 1, instr_gnt,
                         data_gnt, want_i, !want_i);
                errors++;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_out_of_range();
        data_req = 1'b1; data_addr = 9'h100;
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1 || ram_en !== 1'b0) begin
            $display("FAIL oor_grant: got g=%b en=%b want 1 0", data_gnt, ram_en);
            errors++;
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (data_rvalid !== 1'b1 || data_err !== 1'b1 || data_rdata !== 32'h0) begin
            $display("FAIL oor_resp: got rv=%b err=%b rd=%h want 1 1 0", data_rvalid, data_err,
                     data_rdata);
            errors++;
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (data_err !== 1'b0 || data_rvalid !== 1'b0) begin
            $display("FAIL oor_clear: got rv=%b err=%b want 0 0", data_rvalid, data_err);
            errors++;
        end
        next_cycle();
    endtask

    task automatic test_reset_rvalid();
        instr_req = 1'b1; instr_addr = 9'h010;
        @(negedge clk);
        checks++;
        if (instr_gnt !== 1'b1) begin
            $display("FAIL rst_pre_gnt: got %b want 1", instr_gnt);
            errors++;
        end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        data_req = 1'b1; data_addr = 9'h010;
        @(negedge clk);
        checks++;
        if (instr_rvalid !== 1'b1 || instr_rdata !== 32'hDEAD_ABEF) begin
            $display("FAIL rst_rvalid: got rv=%b rd=%h want 1 deadabef", instr_rvalid, instr_rdata);
            errors++;
        end
        checks++;
        if (data_gnt !== 1'b0 || ram_en !== 1'b0) begin
            $display("FAIL rst_force: got g=%b en=%b want 0 0", data_gnt, ram_en);
            errors++;
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err, ram_en, ram_we} !== 7'b0 ||
            instr_rdata !== 32'h0 || data_rdata !== 32'h0 || ram_addr !== '0 ||
            ram_be !== 4'h0 || ram_wdata !== 32'h0) begin
            $display("FAIL rst_all_zero: got ctl=%b ird=%h drd=%h want all 0",
                     {instr_gnt, instr_rvalid, data_gnt, data_rvalid, data_err, ram_en, ram_we},
                     instr_rdata, data_rdata);
            errors++;
        end
        idle_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    // Build the stall count to 3, reset, then the full 4-cycle wait must apply again.
    task automatic test_stall_reset();
        logic want_i;
        data_req = 1'b1; data_addr = 9'h010;
        instr_req = 1'b1; instr_addr = 9'h010;
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            want_i = (k == 4);
            @(negedge clk);
            checks++;
            if (instr_gnt !== want_i || data_gnt !== !want_i) begin
                $display("FAIL stall_clr_cycle%0d: got i=%b d=%b want i=%b d=%b", k + 1,
                         instr_gnt, data_gnt, want_i, !want_i);
                errors++;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

`ifdef SP_RAM_ARB_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        data_req = 1'b1; data_addr = 9'h010;
        instr_req = 1'b1; instr_addr = 9'h010;
        for (int k = 0; k < 10; k++) next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 32'd10) begin
            $display("FAIL perf_count: got %0d want 10", conflict_cnt);
            errors++;
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 32'd0) begin
            $display("FAIL perf_reset: got %0d want 0", conflict_cnt);
            errors++;
        end
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_write_then_fetch();
        test_byte_enable();
        test_age();
        test_out_of_range();
        test_reset_rvalid();
        test_stall_reset();
`ifdef SP_RAM_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
